// File: rtl/fifo_pkg.sv
// Shared types and default widths for the FIFO read-side controller.
package fifo_pkg;

  localparam int unsigned DSIZE_DEF = 8;
  localparam int unsigned CNTW_DEF  = 16;

  // Encoding equals buffer occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry output buffer between the FIFO head and the downstream handshake.
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [DSIZE-1:0] din,
  output state_e           state,
  output logic             valid,
  output logic [DSIZE-1:0] dout
);

  state_e           state_q, state_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] tail_q, tail_d;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_d  = din;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_d = din;
          end else if (push) begin
            tail_d  = din;
            state_d = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Controller never pushes while full, so only a pop moves us.
          if (pop) begin
            head_d  = tail_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign state = state_q;
  assign valid = (state_q != ST_EMPTY);
  assign dout  = head_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: pop strobe, flush/drain and downstream buffering.
// Define FIFO_RD_CTRL_STATS_EN to enable the transfer/starvation counters.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned CNTW  = CNTW_DEF
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             rflush,
  output logic             rdrained,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic [CNTW-1:0]  xfer_cnt,
  output logic [CNTW-1:0]  starve_cnt
);

  state_e state;
  logic   xfer;
  logic   push;
  logic   rdrained_q;

  // Pop decision depends only on registered state, never on m_ready.
  assign rinc = rrst_n & ~rempty & (rflush | (state != ST_TWO));
  assign push = rinc & ~rflush;
  assign xfer = m_valid & m_ready;

  rd_skid_buf #(
    .DSIZE(DSIZE)
  ) u_buf (
    .rclk  (rclk),
    .rrst_n(rrst_n),
    .push  (push),
    .pop   (xfer),
    .flush (rflush),
    .din   (rdata),
    .state (state),
    .valid (m_valid),
    .dout  (m_data)
  );

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rdrained_q <= 1'b0;
    end else begin
      rdrained_q <= rflush & rempty & (state == ST_EMPTY);
    end
  end

  assign rdrained = rdrained_q;

`ifdef FIFO_RD_CTRL_STATS_EN
  localparam logic [CNTW-1:0] CntOne = {{(CNTW-1){1'b0}}, 1'b1};

  logic            starve;
  logic [CNTW-1:0] xfer_cnt_q;
  logic [CNTW-1:0] starve_cnt_q;

  assign starve = m_ready & ~m_valid;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      xfer_cnt_q   <= '0;
      starve_cnt_q <= '0;
    end else begin
      if (xfer && !rflush && (xfer_cnt_q != '1)) begin
        xfer_cnt_q <= xfer_cnt_q + CntOne;
      end
      if (starve && (starve_cnt_q != '1)) begin
        starve_cnt_q <= starve_cnt_q + CntOne;
      end
    end
  end

  assign xfer_cnt   = xfer_cnt_q;
  assign starve_cnt = starve_cnt_q;
`else
  assign xfer_cnt   = '0;
  assign starve_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: cycle vector table plus multi-cycle sequences.
module tb_fifo_rd_ctrl;

`ifdef FIFO_RD_CTRL_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic       rflush;
  logic       rdrained;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [3:0] xfer_cnt;
  logic [3:0] starve_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] fq[$];
  logic [7:0] rx[$];
  int         npop;

  always #5 rclk = ~rclk;

  fifo_rd_ctrl #(
    .DSIZE(8),
    .CNTW (4)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .rflush    (rflush),
    .rdrained  (rdrained),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .xfer_cnt  (xfer_cnt),
    .starve_cnt(starve_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] cnt_exp(input logic [3:0] v);
    return Stats ? v : 4'd0;
  endfunction

  task automatic do_reset();
    rrst_n  = 1'b0;
    rflush  = 1'b0;
    m_ready = 1'b0;
    rempty  = 1'b1;
    rdata   = 8'h00;
    repeat (2) @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  // One cycle against the bench FIFO model; entered and left at a falling edge.
  task automatic step();
    logic pop;
    rempty = (fq.size() == 0);
    rdata  = rempty ? 8'h00 : fq[0];
    #1;
    pop = rinc;
    chk("no_underflow", {31'd0, rinc & rempty}, 32'd0);
    if (pop) npop++;
    if (m_valid && m_ready && !rflush) rx.push_back(m_data);
    @(posedge rclk);
    #1;
    if (pop) void'(fq.pop_front());
    @(negedge rclk);
  endtask

  typedef struct packed {
    logic       rst;
    logic       emp;
    logic [7:0] rd;
    logic       rdy;
    logic       exp_rinc;
    logic       exp_valid;
    logic       chk_d;
    logic [7:0] exp_data;
    logic [3:0] exp_x;
    logic [3:0] exp_s;
  } vec_t;

  localparam int NVec = 15;
  vec_t vecs[NVec];

  initial begin
    // Streaming: 0x11,0x22,0x33 with m_ready held high.
    vecs[0]  = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 4'd0};
    vecs[1]  = '{1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 4'd0, 4'd1};
    vecs[2]  = '{1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 4'd1, 4'd1};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 4'd2, 4'd1};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd3, 4'd1};
    // Backpressure: five words, two pops then stall, then drain in order.
    vecs[5]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 4'd0};
    vecs[6]  = '{1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 4'd0, 4'd0};
    vecs[7]  = '{1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 4'd0, 4'd0};
    vecs[8]  = '{1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 4'd0, 4'd0};
    vecs[9]  = '{1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 4'd0, 4'd0};
    vecs[10] = '{1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 4'd1, 4'd0};
    vecs[11] = '{1'b0, 1'b0, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 4'd2, 4'd0};
    vecs[12] = '{1'b0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 4'd3, 4'd0};
    vecs[13] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 4'd4, 4'd0};
    vecs[14] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd5, 4'd0};

    rrst_n  = 1'b0;
    rempty  = 1'b0;
    rdata   = 8'h5A;
    rflush  = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(negedge rclk);
    chk("rst_rinc", {31'd0, rinc}, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data", {24'd0, m_data}, 32'd0);
    chk("rst_drained", {31'd0, rdrained}, 32'd0);
    chk("rst_xfer", {28'd0, xfer_cnt}, 32'd0);
    chk("rst_starve", {28'd0, starve_cnt}, 32'd0);

    for (int i = 0; i < NVec; i++) begin
      if (vecs[i].rst) do_reset();
      rempty  = vecs[i].emp;
      rdata   = vecs[i].rd;
      m_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_rinc", i), {31'd0, rinc}, {31'd0, vecs[i].exp_rinc});
      chk($sformatf("v%0d_valid", i), {31'd0, m_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].chk_d) chk($sformatf("v%0d_data", i), {24'd0, m_data}, {24'd0, vecs[i].exp_data});
      chk($sformatf("v%0d_xfer", i), {28'd0, xfer_cnt}, {28'd0, cnt_exp(vecs[i].exp_x)});
      chk($sformatf("v%0d_starve", i), {28'd0, starve_cnt}, {28'd0, cnt_exp(vecs[i].exp_s)});
      chk($sformatf("v%0d_drained", i), {31'd0, rdrained}, 32'd0);
      @(posedge rclk);
      @(negedge rclk);
    end

    // Starvation: empty FIFO, downstream ready for 10 cycles.
    do_reset();
    fq.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("starve_valid", {31'd0, m_valid}, 32'd0);
    end
    chk("starve_rinc", {31'd0, rinc}, 32'd0);
    chk("starve_cnt10", {28'd0, starve_cnt}, {28'd0, cnt_exp(4'd10)});

    // Flush from ST_TWO with three words still in the FIFO.
    do_reset();
    fq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    rx.delete();
    npop = 0;
    m_ready = 1'b0;
    repeat (3) step();
    chk("fl_prepops", npop, 32'd2);
    chk("fl_prevalid", {31'd0, m_valid}, 32'd1);
    chk("fl_predata", {24'd0, m_data}, 32'h0000_00A1);
    rflush  = 1'b1;
    m_ready = 1'b1;
    npop    = 0;
    step();
    chk("fl_valid_drop", {31'd0, m_valid}, 32'd0);
    for (int i = 0; i < 8 && !rdrained; i++) step();
    chk("fl_drained", {31'd0, rdrained}, 32'd1);
    chk("fl_pops", npop, 32'd3);
    chk("fl_fifo_empty", fq.size(), 32'd0);
    chk("fl_xfer", {28'd0, xfer_cnt}, 32'd0);
    chk("fl_no_rx", rx.size(), 32'd0);
    rflush = 1'b0;
    step();
    chk("fl_drained_clr", {31'd0, rdrained}, 32'd0);

    // Twenty words streamed: order preserved, counter saturates at 15.
    do_reset();
    fq.delete();
    rx.delete();
    for (int i = 0; i < 20; i++) fq.push_back(8'(i + 1));
    m_ready = 1'b1;
    repeat (24) step();
    chk("sat_rx_count", rx.size(), 32'd20);
    begin
      int bad = 0;
      for (int i = 0; i < rx.size(); i++) if (rx[i] !== 8'(i + 1)) bad++;
      chk("sat_order", bad, 32'd0);
    end
    chk("sat_xfer", {28'd0, xfer_cnt}, {28'd0, cnt_exp(4'd15)});

    // Asynchronous reset in the middle of a stream.
    do_reset();
    fq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    m_ready = 1'b1;
    repeat (3) step();
    chk("mid_valid_pre", {31'd0, m_valid}, 32'd1);
    #2;
    rrst_n = 1'b0;
    #1;
    chk("mid_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_data", {24'd0, m_data}, 32'd0);
    chk("mid_rinc", {31'd0, rinc}, 32'd0);
    chk("mid_drained", {31'd0, rdrained}, 32'd0);
    chk("mid_xfer", {28'd0, xfer_cnt}, 32'd0);
    chk("mid_starve", {28'd0, starve_cnt}, 32'd0);
    chk("mid_fifo_left", fq.size(), 32'd3);
    @(negedge rclk);
    rrst_n = 1'b1;
    fq.delete();
    step();
    chk("post_rst_rinc", {31'd0, rinc}, 32'd0);
    chk("post_rst_valid", {31'd0, m_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
